cpu_control_unit: RTL
=====================

CPU_CONTROL_UNIT -- requirements
Module: cpu_control_unit

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 28, memory word-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data and instruction width.
REQ-003 SHALL have parameter RESET_PC, default 'h100, first fetch address.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  one-cycle pulse; begins execution from IDLE.
REQ-007 SHALL have port mem_addr  output  ADDR_WIDTH  RAM word address (MAR).
REQ-008 SHALL have port mem_cs  output  1  RAM chip select.
REQ-009 SHALL have port mem_we  output  1  RAM write enable.
REQ-010 SHALL have port mem_oe  output  1  RAM output enable (read).
REQ-011 SHALL have port mem_wdata  output  DATA_WIDTH  store data, equal to AC.
REQ-012 SHALL have port mem_rdata  input  DATA_WIDTH  RAM read data, valid the cycle after the address is presented with mem_oe=1.
REQ-013 SHALL have port alu_left  output  32  ALU left operand, equal to AC.
REQ-014 SHALL have port alu_right  output  32  ALU right operand: MBR for ADD, zero-extended IR[27:20] for ADDI, else 0.
REQ-015 SHALL have port alu_ctrl  output  4  ALU mode; 4'b0010 (add) in EXEC, else 4'b0000.
REQ-016 SHALL have port alu_out  input  32  combinational ALU result, sampled in the same cycle.
REQ-017 SHALL have port pc  output  ADDR_WIDTH  program counter.
REQ-018 SHALL have port ac  output  DATA_WIDTH  accumulator.
REQ-019 SHALL have port halted  output  1  high while in HALTED.
REQ-020 SHALL have port busy  output  1  high in every state except IDLE and HALTED.
REQ-021 SHALL have port instr_done  output  1  one-cycle pulse in the last cycle of each instruction.
REQ-022 SHALL have port illegal_op  output  1  one-cycle pulse in DECODE for opcodes 4'h8-4'hF.

Function
REQ-023 SHALL implement states IDLE, FETCH, FETCH_WAIT, DECODE, MEM_RD, MEM_WAIT, EXEC, MEM_WR, HALTED; all memory outputs registered by state.
REQ-024 IDLE: mem_cs=0, mem_we=0, mem_oe=0; start=1 -> FETCH; start in any other state ignored.
REQ-025 FETCH: mem_addr=pc, cs=1, oe=1, we=0; -> FETCH_WAIT.
REQ-026 FETCH_WAIT: IR <= mem_rdata, pc <= pc+1 (wraps modulo 2^ADDR_WIDTH); -> DECODE.
REQ-027 DECODE dispatches on IR[31:28]: 0 ADD, 1 HALT, 2 LOAD, 3 STORE, 4 CLEAR, 5 SKIP, 6 JUMP, 7 ADDI, 8-F illegal.
REQ-028 ADD/LOAD: DECODE -> MEM_RD (mem_addr=IR[27:0], cs=1, oe=1) -> MEM_WAIT (MBR <= mem_rdata) -> EXEC (ADD: AC <= alu_out; LOAD: AC <= MBR) -> FETCH; 6 cycles total.
REQ-029 STORE: DECODE -> MEM_WR (mem_addr=IR[27:0], cs=1, we=1, oe=0, mem_wdata=AC) -> FETCH; 4 cycles; mem_we high in MEM_WR only.
REQ-030 ADDI: DECODE -> EXEC (AC <= alu_out, right = {24'b0, IR[27:20]}) -> FETCH; 4 cycles.
REQ-031 CLEAR (AC <= 0), JUMP (pc <= IR[27:0]), SKIP, illegal (no-op): complete in DECODE -> FETCH; 3 cycles.
REQ-032 SKIP: pc <= pc+1 if IR[2:0]=3'b010 and AC==0, or 3'b000 and AC signed <0, or 3'b100 and AC signed >0; other IR[2:0] codes are no-ops.
REQ-033 HALT: DECODE -> HALTED, pc <= pc-1 (address of the HALT); HALTED is exited only by reset; memory outputs idle.
REQ-034 ADD overflow SHALL wrap modulo 2^32; no flags.
REQ-035 instr_done SHALL pulse in the final cycle of every instruction, including HALT (DECODE cycle).

Reset
REQ-036 rst_n=0 SHALL immediately force state=IDLE, pc=RESET_PC, AC=IR=MBR=0, mem_cs=mem_we=mem_oe=0, all pulses 0, including mid-instruction (a pending store SHALL NOT complete).
REQ-037 After rst_n deasserts, the block SHALL remain in IDLE until start.

Verification
REQ-038 Reset, start, RAM[100]=2000010E, RAM[10E]=5 -> LOAD in 6 cycles, ac=5, pc=101.
REQ-039 ac=7, STORE 30000110 -> exactly one we=1 cycle, addr=110, wdata=7; RAM[110]=7.
REQ-040 ac=0, SKIP 50000002 -> pc advances by 2; ac=1 -> pc advances by 1; ac=FFFFFFFF, SKIP 50000000 -> pc advances by 2.
REQ-041 Fibonacci program at 'h100 (loop counter 9) -> terminates in HALTED, halted=1, pc=10E, RAM[10F]=34 (decimal).
REQ-042 ADDI 70500000 with ac=FFFFFFFE -> ac=3; opcode 8 -> illegal_op pulse, ac unchanged, 3 cycles.
REQ-043 rst_n low during MEM_WR -> mem_we drops in the same cycle, state IDLE, pc=100.

Source files
------------

// File: rtl/cpu_control_unit.sv
// Accumulator CPU sequencer: fetch/decode/execute FSM driving a synchronous-read RAM
// and an external combinational ALU.
//
// state      | meaning
// IDLE       | waiting for start, memory idle
// FETCH      | present pc to RAM with read enable
// FETCH_WAIT | capture instruction, advance pc
// DECODE     | dispatch; single-cycle ops complete here
// MEM_RD     | present operand address for read
// MEM_WAIT   | capture operand into MBR
// EXEC       | write ALU result or MBR into AC
// MEM_WR     | write AC to operand address
// HALTED     | stopped until reset
module cpu_control_unit #(
  parameter int ADDR_WIDTH = 28,
  parameter int DATA_WIDTH = 32,
  parameter int RESET_PC   = 'h100
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic                  mem_oe,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [31:0]           alu_left,
  output logic [31:0]           alu_right,
  output logic [3:0]            alu_ctrl,
  input  logic [31:0]           alu_out,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [DATA_WIDTH-1:0] ac,
  output logic                  halted,
  output logic                  busy,
  output logic                  instr_done,
  output logic                  illegal_op
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_FETCH_WAIT, S_DECODE, S_MEM_RD,
    S_MEM_WAIT, S_EXEC, S_MEM_WR, S_HALTED
  } state_e;

  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_HALT  = 4'h1;
  localparam logic [3:0] OP_LOAD  = 4'h2;
  localparam logic [3:0] OP_STORE = 4'h3;
  localparam logic [3:0] OP_CLEAR = 4'h4;
  localparam logic [3:0] OP_SKIP  = 4'h5;
  localparam logic [3:0] OP_JUMP  = 4'h6;
  localparam logic [3:0] OP_ADDI  = 4'h7;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] ac_q, ac_d;
  logic [DATA_WIDTH-1:0] ir_q, ir_d;
  logic [DATA_WIDTH-1:0] mbr_q, mbr_d;

  logic [3:0]            opcode;
  logic [ADDR_WIDTH-1:0] op_addr;
  logic                  skip_taken;

  assign opcode  = ir_q[31:28];
  assign op_addr = ir_q[ADDR_WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= ADDR_WIDTH'(RESET_PC);
      ac_q    <= '0;
      ir_q    <= '0;
      mbr_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ac_q    <= ac_d;
      ir_q    <= ir_d;
      mbr_q   <= mbr_d;
    end
  end

  // Skip condition codes look at AC as a signed value.
  always_comb begin
    skip_taken = 1'b0;
    case (ir_q[2:0])
      3'b010:  skip_taken = (ac_q == '0);
      3'b000:  skip_taken = ac_q[DATA_WIDTH-1];
      3'b100:  skip_taken = !ac_q[DATA_WIDTH-1] && (ac_q != '0);
      default: skip_taken = 1'b0;
    endcase
  end

  always_comb begin
    alu_right = 32'h0;
    if (opcode == OP_ADD)       alu_right = mbr_q;
    else if (opcode == OP_ADDI) alu_right = {24'h0, ir_q[27:20]};
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ac_d       = ac_q;
    ir_d       = ir_q;
    mbr_d      = mbr_q;
    mem_addr   = pc_q;
    mem_cs     = 1'b0;
    mem_we     = 1'b0;
    mem_oe     = 1'b0;
    alu_ctrl   = 4'b0000;
    instr_done = 1'b0;
    illegal_op = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_cs  = 1'b1;
        mem_oe  = 1'b1;
        state_d = S_FETCH_WAIT;
      end
      S_FETCH_WAIT: begin
        ir_d    = mem_rdata;
        pc_d    = pc_q + ADDR_WIDTH'(1);
        state_d = S_DECODE;
      end
      S_DECODE: begin
        case (opcode)
          OP_ADD, OP_LOAD: state_d = S_MEM_RD;
          OP_STORE:        state_d = S_MEM_WR;
          OP_ADDI:         state_d = S_EXEC;
          OP_HALT: begin
            // pc already points past the HALT; leave it on the HALT itself.
            pc_d       = pc_q - ADDR_WIDTH'(1);
            instr_done = 1'b1;
            state_d    = S_HALTED;
          end
          OP_CLEAR: begin
            ac_d       = '0;
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end
          OP_SKIP: begin
            if (skip_taken) pc_d = pc_q + ADDR_WIDTH'(1);
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end
          OP_JUMP: begin
            pc_d       = op_addr;
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end
          default: begin
            illegal_op = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end
      S_MEM_RD: begin
        mem_addr = op_addr;
        mem_cs   = 1'b1;
        mem_oe   = 1'b1;
        state_d  = S_MEM_WAIT;
      end
      S_MEM_WAIT: begin
        mbr_d   = mem_rdata;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        alu_ctrl   = 4'b0010;
        ac_d       = (opcode == OP_LOAD) ? mbr_q : alu_out;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WR: begin
        mem_addr   = op_addr;
        mem_cs     = 1'b1;
        mem_we     = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase
  end

  assign mem_wdata = ac_q;
  assign alu_left  = ac_q;
  assign pc        = pc_q;
  assign ac        = ac_q;
  assign halted    = (state_q == S_HALTED);
  assign busy      = (state_q != S_IDLE) && (state_q != S_HALTED);

endmodule
